csr_counter_unit: RTL and testbench
===================================

# csr_counter_unit

Parametrised user-level CSR unit for the RV32IMF core: the register file behind the SYSTEM-opcode CSR instructions. It performs atomic read-modify-write (CSRRW/CSRRS/CSRRC) in one cycle and gates illegal accesses. It holds configurable-width cycle/time/instret counters with per-counter inhibit and a time prescaler. It accrues floating-point exception flags stickily from the FPU and exports the rounding mode. It sits between the decode/execute stage and the FPU.

## Interface
Parameters:
- DATA_WIDTH, 32, CSR data width (XLEN).
- CNT_WIDTH, 64, counter width; legal range DATA_WIDTH+1 .. 2*DATA_WIDTH; high-half reads zero-extend.
- TIME_DIV, 1, clk cycles per time tick; must be >= 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_req_i  in  1  access valid this cycle.
- csr_op_i  in  2  operation: 01 RW, 10 RS (set), 11 RC (clear), 00 read-only.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  DATA_WIDTH  operand (rs1 value or zero-extended zimm).
- csr_rdata_o  out  DATA_WIDTH  pre-write value of csr_addr_i (combinational).
- csr_illegal_o  out  1  access rejected (combinational, only with csr_req_i).
- instret_i  in  1  one-cycle pulse per retired instruction.
- fflags_valid_i  in  1  FPU flags valid.
- fflags_i  in  5  FPU flags NV,DZ,OF,UF,NX.
- csr_frm_o  out  3  rounding mode, fcsr[7:5].

## Operation
- Map: ustatus 0x000 RW (all bits); fflags 0x001 RW [4:0]; frm 0x002 RW [2:0]; fcsr 0x003 RW [7:0] with the upper bits reading 0; cntinh 0x800 RW [2:0] = {IR,TM,CY}.
- The read-only counters are cycle 0xC00, time 0xC01, instret 0xC02 (low halves) and cycleh 0xC80, timeh 0xC81, instreth 0xC82 (high halves).
- Other addresses: reads return 0.
- Effective write: RW always writes. RS/RC write only when csr_wdata_i != 0; op 00 never writes.
- New value: RW uses wdata; RS uses old | wdata; RC uses old & ~wdata. The result is masked to implemented bits.
- csr_illegal_o is asserted when csr_req_i=1 and either the address is unmapped, or an effective write targets 0xC00-0xC82. An illegal access writes nothing. csr_rdata_o is still driven for an illegal access (0 for unmapped addresses).
- Counters wrap from all-ones to 0.
- cycle increments every clock unless CY is set.
- instret increments on instret_i unless IR is set.
- time: a prescaler counts 0..TIME_DIV-1. time increments in the cycle the prescaler equals TIME_DIV-1, and the prescaler returns to 0 in that cycle. When TM is set, the prescaler and time both freeze.
- Flag accrual: when fflags_valid_i=1, fcsr[4:0] |= fflags_i.
- Simultaneous software write to fflags/fcsr and accrual: the stored value is the software new value | fflags_i. Accrued flags are never lost.
- frm writes via frm or fcsr. An RS/RC to fflags/frm computes its new value from the corresponding field only.

## Timing
- Reset: all registers, counters and the prescaler are 0. csr_frm_o=0, csr_illegal_o=0, csr_rdata_o=0 while csr_req_i=0.
- Reads are zero-latency: csr_rdata_o and csr_illegal_o settle in the same cycle as the request, and show the registered (pre-edge) state.
- Writes take effect at the next rising clk edge and are visible to reads in the following cycle.
- A cntinh write takes effect from the next edge. In the write cycle itself, counters obey the old inhibit value.
- Back-to-back requests every cycle are supported; there is no stall and no handshake.
- Reset asserted mid-operation clears everything asynchronously, and any in-flight write is discarded.

## Test plan
- Reset, then read 0xC00 after 10 clocks → rdata=10 (±0 at a defined sample point). Read 0xC80 → 0.
- Preload cycle to 0x0000_0000_FFFF_FFFF by running, or force via a test hook. After one clock, read 0xC00 → 0 and 0xC80 → 1. Full wrap at 2^CNT_WIDTH-1 → 0.
- TIME_DIV=4: 16 clocks → time=4. Then RS 0x800 with 0x2 → time frozen for 8 clocks. Then RC 0x800 with 0x2 → resumes.
- RS 0x001 with 0x01 in the same cycle as fflags_valid_i=1, fflags_i=0x10 → fflags=0x11. Then RW 0x003 with 0xE0 → csr_frm_o=7, fflags=0.
- RW to 0xC02 → illegal=1, instret unchanged. RS to 0xC02 with wdata=0 → illegal=0, rdata=instret. Any access to 0x7FF → illegal=1.
- Pulse instret_i 5 times, with IR set for 2 of those pulses → instret=3. Assert rst_n=0 mid-write → all state 0 and no write applied.

Source files
------------

// File: rtl/csr_counter_unit.sv
// User-level CSR unit: one-cycle CSRRW/RS/RC, illegal-access gating, cycle/time/instret counters
// with per-counter inhibit and a time prescaler, and sticky FPU flag accrual.
module csr_counter_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned TIME_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csr_req_i,
    input  logic [1:0]            csr_op_i,
    input  logic [11:0]           csr_addr_i,
    input  logic [DATA_WIDTH-1:0] csr_wdata_i,
    output logic [DATA_WIDTH-1:0] csr_rdata_o,
    output logic                  csr_illegal_o,
    input  logic                  instret_i,
    input  logic                  fflags_valid_i,
    input  logic [4:0]            fflags_i,
    output logic [2:0]            csr_frm_o
);

    localparam int unsigned HI_WIDTH    = CNT_WIDTH - DATA_WIDTH;
    localparam int unsigned PRESC_WIDTH = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [PRESC_WIDTH-1:0] PRESC_MAX = PRESC_WIDTH'(TIME_DIV - 1);

    localparam logic [11:0] ADDR_USTATUS  = 12'h000;
    localparam logic [11:0] ADDR_FFLAGS   = 12'h001;
    localparam logic [11:0] ADDR_FRM      = 12'h002;
    localparam logic [11:0] ADDR_FCSR     = 12'h003;
    localparam logic [11:0] ADDR_CNTINH   = 12'h800;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_TIME     = 12'hC01;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_TIMEH    = 12'hC81;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

    typedef enum logic [1:0] {
        OpRead = 2'b00,
        OpRw   = 2'b01,
        OpRs   = 2'b10,
        OpRc   = 2'b11
    } csr_op_e;

    logic [DATA_WIDTH-1:0]  ustatus_q, ustatus_d;
    logic [4:0]             fflags_q, fflags_d;
    logic [2:0]             frm_q, frm_d;
    logic [2:0]             cntinh_q, cntinh_d;
    logic [CNT_WIDTH-1:0]   cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0]   time_q, time_d;
    logic [CNT_WIDTH-1:0]   instret_q, instret_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;

    logic [HI_WIDTH-1:0]    cycle_hi, time_hi, instret_hi;
    logic [DATA_WIDTH-1:0]  rd_val;
    logic [DATA_WIDTH-1:0]  new_val;
    logic                   mapped;
    logic                   is_counter;
    logic                   wr_en;
    logic                   illegal;
    logic                   do_write;
    csr_op_e                op;

    assign op         = csr_op_e'(csr_op_i);
    assign cycle_hi   = cycle_q[CNT_WIDTH-1:DATA_WIDTH];
    assign time_hi    = time_q[CNT_WIDTH-1:DATA_WIDTH];
    assign instret_hi = instret_q[CNT_WIDTH-1:DATA_WIDTH];

    // Read mux; narrow fields zero-extend so RS/RC on fflags/frm only see their own field.
    always_comb begin
        rd_val     = '0;
        mapped     = 1'b1;
        is_counter = 1'b0;
        case (csr_addr_i)
            ADDR_USTATUS:  rd_val = ustatus_q;
            ADDR_FFLAGS:   rd_val = DATA_WIDTH'(fflags_q);
            ADDR_FRM:      rd_val = DATA_WIDTH'(frm_q);
            ADDR_FCSR:     rd_val = DATA_WIDTH'({frm_q, fflags_q});
            ADDR_CNTINH:   rd_val = DATA_WIDTH'(cntinh_q);
            ADDR_CYCLE: begin
                rd_val     = cycle_q[DATA_WIDTH-1:0];
                is_counter = 1'b1;
            end
            ADDR_TIME: begin
                rd_val     = time_q[DATA_WIDTH-1:0];
                is_counter = 1'b1;
            end
            ADDR_INSTRET: begin
                rd_val     = instret_q[DATA_WIDTH-1:0];
                is_counter = 1'b1;
            end
            ADDR_CYCLEH: begin
                rd_val     = DATA_WIDTH'(cycle_hi);
                is_counter = 1'b1;
            end
            ADDR_TIMEH: begin
                rd_val     = DATA_WIDTH'(time_hi);
                is_counter = 1'b1;
            end
            ADDR_INSTRETH: begin
                rd_val     = DATA_WIDTH'(instret_hi);
                is_counter = 1'b1;
            end
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        new_val = rd_val;
        wr_en   = 1'b0;
        unique case (op)
            OpRead: begin
                new_val = rd_val;
                wr_en   = 1'b0;
            end
            OpRw: begin
                new_val = csr_wdata_i;
                wr_en   = csr_req_i;
            end
            OpRs: begin
                new_val = rd_val | csr_wdata_i;
                wr_en   = csr_req_i && (csr_wdata_i != '0);
            end
            OpRc: begin
                new_val = rd_val & ~csr_wdata_i;
                wr_en   = csr_req_i && (csr_wdata_i != '0);
            end
        endcase
        illegal  = csr_req_i && (!mapped || (is_counter && wr_en));
        do_write = wr_en && !illegal;
    end

    always_comb begin
        ustatus_d = ustatus_q;
        fflags_d  = fflags_q;
        frm_d     = frm_q;
        cntinh_d  = cntinh_q;
        if (do_write) begin
            case (csr_addr_i)
                ADDR_USTATUS: ustatus_d = new_val;
                ADDR_FFLAGS:  fflags_d  = new_val[4:0];
                ADDR_FRM:     frm_d     = new_val[2:0];
                ADDR_FCSR: begin
                    fflags_d = new_val[4:0];
                    frm_d    = new_val[7:5];
                end
                ADDR_CNTINH:  cntinh_d  = new_val[2:0];
                default: ;
            endcase
        end
        // Accrual is applied on top of any software write so no hardware flag is ever dropped.
        if (fflags_valid_i) begin
            fflags_d = fflags_d | fflags_i;
        end
    end

    // Counters obey the registered inhibit bits, so a cntinh write only acts from the next edge.
    always_comb begin
        cycle_d   = cntinh_q[0] ? cycle_q : cycle_q + CNT_WIDTH'(1);
        instret_d = (instret_i && !cntinh_q[2]) ? instret_q + CNT_WIDTH'(1) : instret_q;
        time_d    = time_q;
        presc_d   = presc_q;
        if (!cntinh_q[1]) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                time_d  = time_q + CNT_WIDTH'(1);
            end else begin
                presc_d = presc_q + PRESC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ustatus_q <= '0;
            fflags_q  <= '0;
            frm_q     <= '0;
            cntinh_q  <= '0;
            cycle_q   <= '0;
            time_q    <= '0;
            instret_q <= '0;
            presc_q   <= '0;
        end else begin
            ustatus_q <= ustatus_d;
            fflags_q  <= fflags_d;
            frm_q     <= frm_d;
            cntinh_q  <= cntinh_d;
            cycle_q   <= cycle_d;
            time_q    <= time_d;
            instret_q <= instret_d;
            presc_q   <= presc_d;
        end
    end

    assign csr_rdata_o   = csr_req_i ? rd_val : '0;
    assign csr_illegal_o = illegal;
    assign csr_frm_o     = frm_q;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed self-checking bench for csr_counter_unit: a TIME_DIV=4 instance for most features
// and a narrow 8/16-bit instance for counter half-carry and full wrap.
module tb_csr_counter_unit;

    logic        clk;
    logic        rst_n;
    logic        csr_req;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret;
    logic        fflags_valid;
    logic [4:0]  fflags;
    logic [2:0]  csr_frm;

    logic        s_rst_n;
    logic        s_req;
    logic [11:0] s_addr;
    logic [1:0]  s_op;
    logic [7:0]  s_wdata;
    logic [7:0]  s_rdata;
    logic        s_illegal;
    logic        s_instret;
    logic        s_fvalid;
    logic [4:0]  s_fflags;
    logic [2:0]  s_frm;

    int pass_cnt;
    int total_cnt;

    csr_counter_unit #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (64),
        .TIME_DIV  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_req_i     (csr_req),
        .csr_op_i      (csr_op),
        .csr_addr_i    (csr_addr),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .csr_illegal_o (csr_illegal),
        .instret_i     (instret),
        .fflags_valid_i(fflags_valid),
        .fflags_i      (fflags),
        .csr_frm_o     (csr_frm)
    );

    csr_counter_unit #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (16),
        .TIME_DIV  (1)
    ) dut_s (
        .clk           (clk),
        .rst_n         (s_rst_n),
        .csr_req_i     (s_req),
        .csr_op_i      (s_op),
        .csr_addr_i    (s_addr),
        .csr_wdata_i   (s_wdata),
        .csr_rdata_o   (s_rdata),
        .csr_illegal_o (s_illegal),
        .instret_i     (s_instret),
        .fflags_valid_i(s_fvalid),
        .fflags_i      (s_fflags),
        .csr_frm_o     (s_frm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        csr_req   = 1'b0;
        csr_op    = 2'b00;
        csr_addr  = 12'h000;
        csr_wdata = 32'h0;
    endtask

    // Present a request and let the combinational outputs settle; the edge is up to the caller.
    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata);
        csr_req   = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wdata;
        #1;
    endtask

    task automatic do_reset();
        idle();
        instret      = 1'b0;
        fflags_valid = 1'b0;
        fflags       = 5'h0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL reset_rdata_idle: got %h want %h", csr_rdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (csr_illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", csr_illegal);
        else pass_cnt++;
        total_cnt++;
        if (csr_frm !== 3'h0) $display("FAIL reset_frm: got %h want 0", csr_frm);
        else pass_cnt++;
        do_reset();
        drive(2'b00, 12'hC00, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL reset_cycle: got %h want 0", csr_rdata);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_cycle();
        do_reset();
        repeat (10) tick();
        drive(2'b00, 12'hC00, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'd10) $display("FAIL cycle_10: got %0d want 10", csr_rdata);
        else pass_cnt++;
        drive(2'b00, 12'hC80, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL cycleh_0: got %h want 0", csr_rdata);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_time();
        do_reset();
        repeat (16) tick();
        drive(2'b00, 12'hC01, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'd4) $display("FAIL time_16clk: got %0d want 4", csr_rdata);
        else pass_cnt++;
        drive(2'b10, 12'h800, 32'h2);
        total_cnt++;
        if (csr_illegal !== 1'b0) $display("FAIL cntinh_rs_illegal: got %b want 0", csr_illegal);
        else pass_cnt++;
        tick();
        idle();
        repeat (8) tick();
        drive(2'b00, 12'hC01, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'd4) $display("FAIL time_frozen: got %0d want 4", csr_rdata);
        else pass_cnt++;
        drive(2'b00, 12'h800, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h2) $display("FAIL cntinh_read: got %h want 2", csr_rdata);
        else pass_cnt++;
        drive(2'b11, 12'h800, 32'h2);
        tick();
        idle();
        // Prescaler froze at 1: two more edges reach 3, the third ticks time.
        repeat (2) tick();
        drive(2'b00, 12'hC01, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'd4) $display("FAIL time_resume_pre: got %0d want 4", csr_rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (csr_rdata !== 32'd5) $display("FAIL time_resume: got %0d want 5", csr_rdata);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_fflags();
        do_reset();
        drive(2'b10, 12'h001, 32'h01);
        fflags_valid = 1'b1;
        fflags       = 5'h10;
        tick();
        fflags_valid = 1'b0;
        fflags       = 5'h0;
        drive(2'b00, 12'h001, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h11) $display("FAIL fflags_merge: got %h want 11", csr_rdata);
        else pass_cnt++;
        drive(2'b01, 12'h003, 32'hE0);
        tick();
        total_cnt++;
        if (csr_frm !== 3'h7) $display("FAIL fcsr_frm_out: got %h want 7", csr_frm);
        else pass_cnt++;
        drive(2'b00, 12'h001, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL fcsr_fflags_clr: got %h want 0", csr_rdata);
        else pass_cnt++;
        drive(2'b00, 12'h003, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'hE0) $display("FAIL fcsr_read: got %h want e0", csr_rdata);
        else pass_cnt++;
        drive(2'b11, 12'h002, 32'h1);
        tick();
        total_cnt++;
        if (csr_frm !== 3'h6) $display("FAIL frm_rc: got %h want 6", csr_frm);
        else pass_cnt++;
        idle();
        fflags_valid = 1'b1;
        fflags       = 5'h04;
        tick();
        fflags_valid = 1'b0;
        fflags       = 5'h0;
        drive(2'b00, 12'h003, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'hC4) $display("FAIL fflags_accrue: got %h want c4", csr_rdata);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_illegal();
        do_reset();
        repeat (3) begin
            instret = 1'b1;
            tick();
            instret = 1'b0;
            tick();
        end
        drive(2'b01, 12'hC02, 32'h5);
        total_cnt++;
        if (csr_illegal !== 1'b1) $display("FAIL rw_counter_illegal: got %b want 1", csr_illegal);
        else pass_cnt++;
        total_cnt++;
        if (csr_rdata !== 32'd3) $display("FAIL rw_counter_rdata: got %0d want 3", csr_rdata);
        else pass_cnt++;
        tick();
        drive(2'b10, 12'hC02, 32'h0);
        total_cnt++;
        if (csr_illegal !== 1'b0) $display("FAIL rs0_counter_illegal: got %b want 0", csr_illegal);
        else pass_cnt++;
        total_cnt++;
        if (csr_rdata !== 32'd3) $display("FAIL instret_kept: got %0d want 3", csr_rdata);
        else pass_cnt++;
        drive(2'b00, 12'h7FF, 32'h0);
        total_cnt++;
        if (csr_illegal !== 1'b1) $display("FAIL unmapped_read: got %b want 1", csr_illegal);
        else pass_cnt++;
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL unmapped_rdata: got %h want 0", csr_rdata);
        else pass_cnt++;
        drive(2'b01, 12'h000, 32'hDEADBEEF);
        total_cnt++;
        if (csr_illegal !== 1'b0) $display("FAIL ustatus_legal: got %b want 0", csr_illegal);
        else pass_cnt++;
        tick();
        drive(2'b11, 12'h000, 32'h0000FFFF);
        total_cnt++;
        if (csr_rdata !== 32'hDEADBEEF) $display("FAIL ustatus_rw: got %h want deadbeef", csr_rdata);
        else pass_cnt++;
        tick();
        drive(2'b00, 12'h000, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'hDEAD0000) $display("FAIL ustatus_rc: got %h want dead0000", csr_rdata);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_instret_inhibit();
        do_reset();
        repeat (2) begin
            instret = 1'b1;
            tick();
            instret = 1'b0;
            tick();
        end
        drive(2'b10, 12'h800, 32'h4);
        tick();
        idle();
        repeat (2) begin
            instret = 1'b1;
            tick();
            instret = 1'b0;
            tick();
        end
        drive(2'b11, 12'h800, 32'h4);
        tick();
        idle();
        instret = 1'b1;
        tick();
        instret = 1'b0;
        drive(2'b00, 12'hC02, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'd3) $display("FAIL instret_inhibit: got %0d want 3", csr_rdata);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        drive(2'b01, 12'h003, 32'hFF);
        tick();
        drive(2'b01, 12'h000, 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (csr_frm !== 3'h0) $display("FAIL async_reset_frm: got %h want 0", csr_frm);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b00, 12'h000, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL reset_discard_write: got %h want 0", csr_rdata);
        else pass_cnt++;
        drive(2'b00, 12'h003, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL reset_fcsr: got %h want 0", csr_rdata);
        else pass_cnt++;
        drive(2'b00, 12'hC00, 32'h0);
        total_cnt++;
        if (csr_rdata !== 32'h0) $display("FAIL reset_cycle_clr: got %h want 0", csr_rdata);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_wrap();
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
        s_req   = 1'b1;
        s_addr  = 12'hC00;
        repeat (255) tick();
        total_cnt++;
        if (s_rdata !== 8'hFF) $display("FAIL narrow_cycle_255: got %h want ff", s_rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (s_rdata !== 8'h00) $display("FAIL narrow_cycle_lo_wrap: got %h want 00", s_rdata);
        else pass_cnt++;
        s_addr = 12'hC80;
        #1;
        total_cnt++;
        if (s_rdata !== 8'h01) $display("FAIL narrow_cycleh_carry: got %h want 01", s_rdata);
        else pass_cnt++;
        s_addr = 12'hC81;
        #1;
        total_cnt++;
        if (s_rdata !== 8'h01) $display("FAIL narrow_timeh_div1: got %h want 01", s_rdata);
        else pass_cnt++;
        s_addr = 12'hC80;
        repeat (65279) tick();
        total_cnt++;
        if (s_rdata !== 8'hFF) $display("FAIL narrow_cycleh_max: got %h want ff", s_rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (s_rdata !== 8'h00) $display("FAIL narrow_full_wrap_hi: got %h want 00", s_rdata);
        else pass_cnt++;
        s_addr = 12'hC00;
        #1;
        total_cnt++;
        if (s_rdata !== 8'h00) $display("FAIL narrow_full_wrap_lo: got %h want 00", s_rdata);
        else pass_cnt++;
        s_req = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n        = 1'b0;
        instret      = 1'b0;
        fflags_valid = 1'b0;
        fflags       = 5'h0;
        idle();
        s_rst_n   = 1'b0;
        s_req     = 1'b0;
        s_addr    = 12'h000;
        s_op      = 2'b00;
        s_wdata   = 8'h00;
        s_instret = 1'b0;
        s_fvalid  = 1'b0;
        s_fflags  = 5'h0;

        test_reset();
        test_cycle();
        test_time();
        test_fflags();
        test_illegal();
        test_instret_inhibit();
        test_reset_mid_write();
        test_wrap();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
